// File: rtl/layer_stream_ctl.sv
// Command/data byte-stream decoder: turns SPI bytes into layer RAM write address, lane and strobes.
// Optional sticky protocol error output enabled by defining LAYER_STREAM_ERR_EN.
module layer_stream_ctl #(
  parameter int unsigned LAYERS      = 8,
  parameter int unsigned PIXELS      = 64,
  parameter int unsigned COLORS      = 3,
  parameter int unsigned ADDR_W      = (PIXELS > 1) ? $clog2(PIXELS) : 1,
  parameter logic [7:0]  CMD_ADDR_WR = 8'hcc,
  parameter logic [7:0]  CMD_DATA_WR = 8'hda
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              dc_in,
  input  logic              byte_rdy_in,
  input  logic [7:0]        byte_data_in,
  output logic              frame_rdy_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [COLORS:0]   byte_en_out,
  output logic [LAYERS-1:0] layer_en_out,
  output logic              busy_out
`ifdef LAYER_STREAM_ERR_EN
  ,
  output logic              err_out
`endif
);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  localparam logic [ADDR_W-1:0] LastAddr   = ADDR_W'(PIXELS - 1);
  localparam logic [COLORS-1:0] ColourMsb  = COLORS'(1 << (COLORS - 1));
  localparam logic [LAYERS-1:0] LayerFirst = LAYERS'(1);

  state_e            r_state, w_state_d;
  logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_d;
  logic              r_addr_lane, w_addr_lane_d;
  logic [COLORS-1:0] r_colour, w_colour_d;
  logic [LAYERS-1:0] r_layer, w_layer_d;
  logic              r_frame_rdy, w_frame_rdy_d;
  logic [COLORS-1:0] w_colour_rot;

  assign w_colour_rot = (r_colour >> 1) | (r_colour[0] ? ColourMsb : '0);

  always_comb begin
    w_state_d     = r_state;
    w_wr_addr_d   = r_wr_addr;
    w_addr_lane_d = r_addr_lane;
    w_colour_d    = r_colour;
    w_layer_d     = r_layer;
    w_frame_rdy_d = 1'b0;
    if (byte_rdy_in) begin
      if (!dc_in) begin
        // Any command restarts from pixel 0, discarding whatever was in flight.
        w_wr_addr_d = '0;
        if (byte_data_in == CMD_ADDR_WR) begin
          w_state_d     = StAddr;
          w_addr_lane_d = 1'b1;
          w_colour_d    = '0;
          w_layer_d     = '1;
        end else if (byte_data_in == CMD_DATA_WR) begin
          w_state_d     = StData;
          w_addr_lane_d = 1'b0;
          w_colour_d    = ColourMsb;
          w_layer_d     = LayerFirst;
        end else begin
          w_state_d     = StIdle;
          w_addr_lane_d = 1'b0;
          w_colour_d    = '0;
          w_layer_d     = '0;
        end
      end else begin
        unique case (r_state)
          StAddr: begin
            if (r_wr_addr == LastAddr) begin
              w_wr_addr_d   = '0;
              w_layer_d     = '0;
              w_addr_lane_d = 1'b0;
              w_state_d     = StIdle;
            end else begin
              w_wr_addr_d = r_wr_addr + 1'b1;
            end
          end
          StData: begin
            w_colour_d = w_colour_rot;
            if (r_colour[0]) begin
              if (r_wr_addr == LastAddr) begin
                w_wr_addr_d = '0;
                if (r_layer[LAYERS-1]) begin
                  w_layer_d     = '0;
                  w_colour_d    = '0;
                  w_state_d     = StIdle;
                  w_frame_rdy_d = 1'b1;
                end else begin
                  w_layer_d = r_layer << 1;
                end
              end else begin
                w_wr_addr_d = r_wr_addr + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state     <= StIdle;
      r_wr_addr   <= '0;
      r_addr_lane <= 1'b0;
      r_colour    <= '0;
      r_layer     <= '0;
      r_frame_rdy <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_wr_addr   <= w_wr_addr_d;
      r_addr_lane <= w_addr_lane_d;
      r_colour    <= w_colour_d;
      r_layer     <= w_layer_d;
      r_frame_rdy <= w_frame_rdy_d;
    end
  end

  assign frame_rdy_out = r_frame_rdy;
  assign wr_addr_out   = r_wr_addr;
  assign byte_en_out   = {r_addr_lane, r_colour};
  // Combinational gate so the RAM write lands in the strobe cycle itself.
  assign layer_en_out  = r_layer & {LAYERS{byte_rdy_in & dc_in}};
  assign busy_out      = (r_state != StIdle);

`ifdef LAYER_STREAM_ERR_EN
  logic r_err;
  logic w_err_set, w_err_clr, w_partial;

  // DATA at pixel 0, first colour, first layer means no data byte has arrived yet.
  assign w_partial = (r_state == StData) &&
                     !((r_wr_addr == '0) && (r_colour == ColourMsb) && (r_layer == LayerFirst));
  assign w_err_set = byte_rdy_in &
                     ((dc_in & (r_state == StIdle)) |
                      (~dc_in & (byte_data_in != CMD_ADDR_WR) & (byte_data_in != CMD_DATA_WR)) |
                      (~dc_in & w_partial));
  assign w_err_clr = byte_rdy_in & ~dc_in & (byte_data_in == CMD_DATA_WR);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end else if (w_err_clr) begin
      r_err <= 1'b0;
    end
  end

  assign err_out = r_err;
`endif

endmodule

// File: tb/tb_layer_stream_ctl.sv
// Bench for layer_stream_ctl: default instance plus a 4x10x4 instance driven by the same stream,
// both checked every cycle against a byte-count reference model.
module tb_layer_stream_ctl;

  localparam int L0 = 8;
  localparam int P0 = 64;
  localparam int C0 = 3;
  localparam int L1 = 4;
  localparam int P1 = 10;
  localparam int C1 = 4;

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic       dc_in;
  logic       byte_rdy_in;
  logic [7:0] byte_data_in;

  logic       frame0, busy0;
  logic [5:0] addr0;
  logic [3:0] ben0;
  logic [7:0] layer0;
  logic       frame1, busy1;
  logic [3:0] addr1;
  logic [4:0] ben1;
  logic [3:0] layer1;
`ifdef LAYER_STREAM_ERR_EN
  logic       err0, err1;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Model: mode 0=idle 1=addr-map 2=colour; cnt = data bytes accepted in the current transfer.
  int m_mode[2];
  int m_cnt[2];
  int m_frame[2];
  int m_err[2];

  always #5 clk_in = ~clk_in;

  layer_stream_ctl dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .dc_in        (dc_in),
    .byte_rdy_in  (byte_rdy_in),
    .byte_data_in (byte_data_in),
    .frame_rdy_out(frame0),
    .wr_addr_out  (addr0),
    .byte_en_out  (ben0),
    .layer_en_out (layer0),
    .busy_out     (busy0)
`ifdef LAYER_STREAM_ERR_EN
    ,
    .err_out      (err0)
`endif
  );

  layer_stream_ctl #(
    .LAYERS(L1),
    .PIXELS(P1),
    .COLORS(C1)
  ) dut6 (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .dc_in        (dc_in),
    .byte_rdy_in  (byte_rdy_in),
    .byte_data_in (byte_data_in),
    .frame_rdy_out(frame1),
    .wr_addr_out  (addr1),
    .byte_en_out  (ben1),
    .layer_en_out (layer1),
    .busy_out     (busy1)
`ifdef LAYER_STREAM_ERR_EN
    ,
    .err_out      (err1)
`endif
  );

  function automatic int p_l(int id); return (id == 0) ? L0 : L1; endfunction
  function automatic int p_p(int id); return (id == 0) ? P0 : P1; endfunction
  function automatic int p_c(int id); return (id == 0) ? C0 : C1; endfunction

  function automatic logic [31:0] e_addr(int id);
    if (m_mode[id] == 1) return 32'(m_cnt[id]);
    if (m_mode[id] == 2) return 32'((m_cnt[id] / p_c(id)) % p_p(id));
    return 32'd0;
  endfunction

  function automatic logic [31:0] e_ben(int id);
    if (m_mode[id] == 1) return 32'd1 << p_c(id);
    if (m_mode[id] == 2) return 32'd1 << (p_c(id) - 1 - (m_cnt[id] % p_c(id)));
    return 32'd0;
  endfunction

  function automatic logic [31:0] e_layer(int id);
    if (!(byte_rdy_in && dc_in)) return 32'd0;
    if (m_mode[id] == 1) return 32'((1 << p_l(id)) - 1);
    if (m_mode[id] == 2) return 32'd1 << (m_cnt[id] / (p_p(id) * p_c(id)));
    return 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("addr0",  32'(addr0),  e_addr(0));
    chk("ben0",   32'(ben0),   e_ben(0));
    chk("layer0", 32'(layer0), e_layer(0));
    chk("busy0",  32'(busy0),  32'(m_mode[0] != 0));
    chk("frame0", 32'(frame0), 32'(m_frame[0]));
    chk("addr1",  32'(addr1),  e_addr(1));
    chk("ben1",   32'(ben1),   e_ben(1));
    chk("layer1", 32'(layer1), e_layer(1));
    chk("busy1",  32'(busy1),  32'(m_mode[1] != 0));
    chk("frame1", 32'(frame1), 32'(m_frame[1]));
`ifdef LAYER_STREAM_ERR_EN
    chk("err0",   32'(err0),   32'(m_err[0]));
    chk("err1",   32'(err1),   32'(m_err[1]));
`endif
  endtask

  task automatic model_reset();
    for (int id = 0; id < 2; id++) begin
      m_mode[id]  = 0;
      m_cnt[id]   = 0;
      m_frame[id] = 0;
      m_err[id]   = 0;
    end
  endtask

  task automatic model_step(input logic rdy, input logic dc, input logic [7:0] d);
    for (int id = 0; id < 2; id++) begin
      bit set, clr;
      m_frame[id] = 0;
      if (rdy) begin
        set = (dc && m_mode[id] == 0) ||
              (!dc && d != 8'hcc && d != 8'hda) ||
              (!dc && m_mode[id] == 2 && m_cnt[id] > 0);
        clr = !dc && d == 8'hda;
        if (set) m_err[id] = 1;
        else if (clr) m_err[id] = 0;
        if (!dc) begin
          m_cnt[id]  = 0;
          m_mode[id] = (d == 8'hcc) ? 1 : (d == 8'hda) ? 2 : 0;
        end else if (m_mode[id] == 1) begin
          m_cnt[id]++;
          if (m_cnt[id] == p_p(id)) begin
            m_mode[id] = 0;
            m_cnt[id]  = 0;
          end
        end else if (m_mode[id] == 2) begin
          m_cnt[id]++;
          if (m_cnt[id] == p_l(id) * p_p(id) * p_c(id)) begin
            m_mode[id]  = 0;
            m_cnt[id]   = 0;
            m_frame[id] = 1;
          end
        end
      end
    end
  endtask

  // One clock: drive at negedge, check before the posedge, advance model for that posedge.
  task automatic cycle(input logic rdy, input logic dc, input logic [7:0] d);
    @(negedge clk_in);
    byte_rdy_in  = rdy;
    dc_in        = dc;
    byte_data_in = d;
    #1;
    check_all();
    model_step(rdy, dc, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00);
  endtask

  task automatic data_bytes(input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      idle(int'($urandom_range(max_gap, 0)));
      cycle(1'b1, 1'b1, 8'($urandom));
    end
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic do_reset();
    #2;
    rst_n_in = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk_in);
    byte_rdy_in = 1'b0;
    dc_in       = 1'b0;
    rst_n_in    = 1'b1;
  endtask

  initial begin
    logic [7:0] cmd;
    rst_n_in     = 1'b0;
    byte_rdy_in  = 1'b0;
    dc_in        = 1'b0;
    byte_data_in = 8'h00;
    model_reset();
    repeat (2) @(negedge clk_in);
    check_all();
    rst_n_in = 1'b1;
    idle(2);

    // Address-map write, then one byte past the end.
    cycle(1'b1, 1'b0, 8'hcc);
    data_bytes(64, 0);
    data_bytes(1, 0);
    idle(2);

    // Full colour frame with random gaps.
    cycle(1'b1, 1'b0, 8'hda);
    data_bytes(L0 * P0 * C0, 2);
    idle(3);

    // Abort a partial frame with an address-map command.
    cycle(1'b1, 1'b0, 8'hda);
    data_bytes(100, 1);
    cycle(1'b1, 1'b0, 8'hcc);
    idle(2);

    // Error set/clear paths and unknown commands.
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'hda);
    cycle(1'b1, 1'b0, 8'h13);
    cycle(1'b1, 1'b1, 8'h5a);
    cycle(1'b1, 1'b0, 8'hcc);
    cycle(1'b1, 1'b0, 8'hda);
    cycle(1'b1, 1'b0, 8'hda);
    cycle(1'b1, 1'b1, 8'h01);
    cycle(1'b1, 1'b0, 8'hda);
    idle(2);

    // Small-instance frame, back-to-back then gapped.
    cycle(1'b1, 1'b0, 8'hda);
    data_bytes(L1 * P1 * C1 + 3, 0);
    idle(2);
    cycle(1'b1, 1'b0, 8'hda);
    data_bytes(L1 * P1 * C1, 3);
    idle(2);

    // Reset in the middle of a colour transfer.
    cycle(1'b1, 1'b0, 8'hda);
    data_bytes(50, 0);
    cycle(1'b0, 1'b0, 8'h00);
    do_reset();
    idle(2);

    // Reset while the small instance's frame pulse is high cancels it.
    cycle(1'b1, 1'b0, 8'hda);
    data_bytes(L1 * P1 * C1, 0);
    @(posedge clk_in);
    #1;
    chk("frame1_pending", 32'(frame1), 32'(m_frame[1]));
    do_reset();
    idle(3);

    // Random mix of commands and data.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3, 0) == 0) begin
        cycle(1'b0, 1'($urandom), 8'($urandom));
      end else if ($urandom_range(99, 0) < 2) begin
        case ($urandom_range(2, 0))
          0:       cmd = 8'hcc;
          1:       cmd = 8'hda;
          default: cmd = 8'($urandom);
        endcase
        cycle(1'b1, 1'b0, cmd);
      end else begin
        cycle(1'b1, 1'b1, 8'($urandom));
      end
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
